// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes, FSM state types and seven-segment table
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_HAVE_AW = 2'd1,
      W_HAVE_W  = 2'd2,
      W_RESP    = 2'd3
   } w_state_e;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_VALID = 1'b1
   } r_state_e;

   // Active-high segments, bit0=a .. bit6=g, bit7=dp (always off)
   localparam logic [7:0] SEG7_TABLE [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational nibble to seven-segment decoder
module hex7seg_dec
   import axi_lite_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [7:0] seg_o
);

   assign seg_o = SEG7_TABLE[nibble_i];

endmodule

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI-Lite-style register file with OKAY/SLVERR responses
// Optional hex display of the last OKAY read under AXI_LITE_REGFILE_HEX_DISP_EN.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_awvalid,
   input  logic [ADDR_W-1:0] s_awaddr,
   output logic              s_awready,
   input  logic              s_wvalid,
   input  logic [DATA_W-1:0] s_wdata,
   output logic              s_wready,
   output logic              s_bvalid,
   output logic [1:0]        s_bresp,
   input  logic              s_bready,
   input  logic              s_arvalid,
   input  logic [ADDR_W-1:0] s_araddr,
   output logic              s_arready,
   output logic              s_rvalid,
   output logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        s_rresp,
   input  logic              s_rready,
   output logic [7:0]        disp_hex
);

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   w_state_e          w_state_q, w_state_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              commit;
   logic              c_ok;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_data;
   logic              aw_hs, w_hs, ar_hs, ar_ok;
   logic [DATA_W-1:0] regs_q [DEPTH];

   r_state_e          r_state_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;

   assign s_awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_W);
   assign s_wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW);
   assign s_bvalid  = (w_state_q == W_RESP);
   assign s_bresp   = bresp_q;
   assign aw_hs     = s_awvalid && s_awready;
   assign w_hs      = s_wvalid && s_wready;

   // Commit address/data come from the bus or from whichever half was latched first
   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      bresp_d   = bresp_q;
      commit    = 1'b0;
      c_addr    = s_awaddr;
      c_data    = s_wdata;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
            end else if (aw_hs) begin
               awaddr_d  = s_awaddr;
               w_state_d = W_HAVE_AW;
            end else if (w_hs) begin
               wdata_d   = s_wdata;
               w_state_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            c_addr = awaddr_q;
            commit = w_hs;
         end
         W_HAVE_W: begin
            c_data = wdata_q;
            commit = aw_hs;
         end
         W_RESP: begin
            if (s_bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
      c_ok = ({1'b0, c_addr} < DEPTH_C);
      if (commit) begin
         w_state_d = W_RESP;
         bresp_d   = c_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         bresp_q   <= bresp_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (commit && c_ok) begin
         regs_q[c_addr] <= c_data;
      end
   end

   assign s_arready = (r_state_q == R_IDLE) || s_rready;
   assign ar_hs     = s_arvalid && s_arready;
   assign ar_ok     = ({1'b0, s_araddr} < DEPTH_C);

   // Reads sample regs_q before any same-edge write lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else if (ar_hs) begin
         r_state_q <= R_VALID;
         rdata_q   <= ar_ok ? regs_q[s_araddr] : '0;
         rresp_q   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_rready) begin
         r_state_q <= R_IDLE;
      end
   end

   assign s_rvalid = (r_state_q == R_VALID);
   assign s_rdata  = rdata_q;
   assign s_rresp  = rresp_q;

`ifdef AXI_LITE_REGFILE_HEX_DISP_EN
   logic [7:0] seg;
   logic [7:0] disp_q;

   hex7seg_dec u_dec (
      .nibble_i (rdata_q[3:0]),
      .seg_o    (seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q <= SEG7_TABLE[0];
      end else if (s_rvalid && s_rready && (rresp_q == RESP_OKAY)) begin
         disp_q <= seg;
      end
   end

   assign disp_hex = disp_q;
`else
   assign disp_hex = 8'h00;
`endif

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - self-checking bench for axi_lite_regfile with a reference memory model
module tb_axi_lite_regfile;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DP = 12;
`ifdef AXI_LITE_REGFILE_HEX_DISP_EN
   localparam bit HEX_EN = 1'b1;
`else
   localparam bit HEX_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
   logic          s_arvalid = 1'b0, s_rready = 1'b0;
   logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
   logic [DW-1:0] s_wdata = '0;
   logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]    s_bresp, s_rresp;
   logic [DW-1:0] s_rdata;
   logic [7:0]    disp_hex;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] model_mem [DP];
   logic [7:0]    model_disp;

   always #5 clk = ~clk;

   axi_lite_regfile #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
      .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
      .disp_hex(disp_hex)
   );

   function automatic logic [7:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
         4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
         4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
         4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
      endcase
   endfunction

   function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
      return (int'(a) < DP) ? model_mem[a] : '0;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
      return (int'(a) < DP) ? 2'b00 : 2'b10;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DP; i++) model_mem[i] = '0;
      model_disp = HEX_EN ? 8'h3F : 8'h00;
   endtask

   task automatic model_read(input logic [AW-1:0] a);
      if (int'(a) < DP && HEX_EN) model_disp = seg_of(model_mem[a][3:0]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int aw_at, input int w_at,
                            output logic bv1, output logic [1:0] resp,
                            output logic bv2, output bit done);
      int t;
      bit aw_d, w_d, af, wf;
      t = 0; aw_d = 0; w_d = 0;
      s_bready = 1'b1;
      if (aw_at == 0) begin s_awvalid = 1'b1; s_awaddr = a; end
      if (w_at == 0) begin s_wvalid = 1'b1; s_wdata = d; end
      while (!(aw_d && w_d) && t < 20) begin
         af = s_awvalid && s_awready;
         wf = s_wvalid && s_wready;
         tick();
         t++;
         if (af) begin aw_d = 1; s_awvalid = 1'b0; end
         if (wf) begin w_d = 1; s_wvalid = 1'b0; end
         if (!aw_d && !s_awvalid && t >= aw_at) begin s_awvalid = 1'b1; s_awaddr = a; end
         if (!w_d && !s_wvalid && t >= w_at) begin s_wvalid = 1'b1; s_wdata = d; end
      end
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      done = aw_d && w_d;
      bv1  = s_bvalid;
      resp = s_bresp;
      tick();
      bv2  = s_bvalid;
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic rv, output logic [DW-1:0] data,
                           output logic [1:0] resp, output logic [7:0] disp, output bit done);
      int t;
      bit f;
      t = 0; done = 0;
      s_arvalid = 1'b1; s_araddr = a; s_rready = 1'b1;
      while (!done && t < 20) begin
         f = s_arready;
         tick();
         t++;
         if (f) done = 1;
      end
      s_arvalid = 1'b0;
      rv   = s_rvalid;
      data = s_rdata;
      resp = s_rresp;
      tick();
      disp = disp_hex;
   endtask

   task automatic test_reset();
      logic rv; logic [DW-1:0] d; logic [1:0] r; logic [7:0] dh; bit ok;
      checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++;
         $display("FAIL reset_ready: got %b expected 111", {s_awready, s_wready, s_arready}); end
      checks++; if ({s_bvalid, s_rvalid, s_bresp, s_rresp} !== 6'b0) begin errors++;
         $display("FAIL reset_resp: got %b expected 000000", {s_bvalid, s_rvalid, s_bresp, s_rresp}); end
      checks++; if (s_rdata !== 8'h00) begin errors++;
         $display("FAIL reset_rdata: got %h expected 00", s_rdata); end
      checks++; if (disp_hex !== model_disp) begin errors++;
         $display("FAIL reset_disp: got %h expected %h", disp_hex, model_disp); end
      for (int i = 0; i < DP; i++) begin
         axi_read(AW'(i), rv, d, r, dh, ok);
         model_read(AW'(i));
         checks++; if (!ok || rv !== 1'b1 || d !== 8'h00 || r !== 2'b00) begin errors++;
            $display("FAIL reset_read[%0d]: got ok=%0d rv=%b d=%h r=%b expected 1 1 00 00", i, ok, rv, d, r); end
      end
      axi_read(4'd3, rv, d, r, dh, ok);
      model_read(4'd3);
      checks++; if (dh !== model_disp) begin errors++;
         $display("FAIL reset_read3_disp: got %h expected %h", dh, model_disp); end
   endtask

   task automatic test_write_same_cycle();
      logic bv1, bv2, rv; logic [1:0] r; logic [DW-1:0] d; logic [7:0] dh; bit ok;
      axi_write(4'd3, 8'h45, 0, 0, bv1, r, bv2, ok);
      model_mem[3] = 8'h45;
      checks++; if (!ok || bv1 !== 1'b1 || r !== 2'b00 || bv2 !== 1'b0) begin errors++;
         $display("FAIL same_cycle_write: got ok=%0d bv=%b%b bresp=%b expected 1 10 00", ok, bv1, bv2, r); end
      axi_read(4'd3, rv, d, r, dh, ok);
      model_read(4'd3);
      checks++; if (!ok || d !== 8'h45 || r !== 2'b00) begin errors++;
         $display("FAIL same_cycle_read: got %h/%b expected 45/00", d, r); end
      checks++; if (dh !== model_disp) begin errors++;
         $display("FAIL same_cycle_disp: got %h expected %h", dh, model_disp); end
   endtask

   task automatic test_w_before_aw();
      logic rv; logic [1:0] r; logic [DW-1:0] d; logic [7:0] dh; bit ok;
      s_bready = 1'b0;
      s_wvalid = 1'b1; s_wdata = 8'hA4;
      tick();
      s_wvalid = 1'b0;
      checks++; if (s_wready !== 1'b0 || s_awready !== 1'b1 || s_bvalid !== 1'b0) begin errors++;
         $display("FAIL w_first_wait: got wr=%b awr=%b bv=%b expected 0 1 0", s_wready, s_awready, s_bvalid); end
      tick();
      tick();
      s_awvalid = 1'b1; s_awaddr = 4'd7;
      tick();
      s_awvalid = 1'b0;
      model_mem[7] = 8'hA4;
      for (int i = 0; i < 4; i++) begin
         checks++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_awready !== 1'b0 || s_wready !== 1'b0) begin errors++;
            $display("FAIL w_first_hold[%0d]: got bv=%b br=%b awr=%b wr=%b expected 1 00 0 0",
                     i, s_bvalid, s_bresp, s_awready, s_wready); end
         if (i < 3) tick();
      end
      s_bready = 1'b1;
      tick();
      checks++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin errors++;
         $display("FAIL w_first_release: got bv=%b awr=%b wr=%b expected 0 1 1", s_bvalid, s_awready, s_wready); end
      axi_read(4'd7, rv, d, r, dh, ok);
      model_read(4'd7);
      checks++; if (!ok || d !== 8'hA4 || r !== 2'b00 || dh !== model_disp) begin errors++;
         $display("FAIL w_first_read: got %h/%b/%h expected a4/00/%h", d, r, dh, model_disp); end
   endtask

   task automatic test_out_of_range();
      logic bv1, bv2, rv; logic [1:0] r; logic [DW-1:0] d; logic [7:0] dh; bit ok;
      axi_write(4'd13, 8'h5A, 1, 0, bv1, r, bv2, ok);
      checks++; if (!ok || bv1 !== 1'b1 || r !== 2'b10) begin errors++;
         $display("FAIL oor_write: got ok=%0d bv=%b bresp=%b expected 1 1 10", ok, bv1, r); end
      axi_read(4'd13, rv, d, r, dh, ok);
      checks++; if (!ok || d !== 8'h00 || r !== 2'b10) begin errors++;
         $display("FAIL oor_read: got %h/%b expected 00/10", d, r); end
      checks++; if (dh !== model_disp) begin errors++;
         $display("FAIL oor_disp: got %h expected %h", dh, model_disp); end
      for (int i = 0; i < DP; i++) begin
         axi_read(AW'(i), rv, d, r, dh, ok);
         model_read(AW'(i));
         checks++; if (!ok || d !== model_mem[i] || r !== 2'b00) begin errors++;
            $display("FAIL oor_intact[%0d]: got %h/%b expected %h/00", i, d, r, model_mem[i]); end
      end
   endtask

   task automatic test_back_to_back();
      s_rready = 1'b1;
      s_arvalid = 1'b1; s_araddr = 4'd3;
      tick();
      checks++; if (s_rvalid !== 1'b1 || s_rdata !== 8'h45 || s_arready !== 1'b1) begin errors++;
         $display("FAIL b2b_first: got rv=%b d=%h arr=%b expected 1 45 1", s_rvalid, s_rdata, s_arready); end
      s_araddr = 4'd7;
      tick();
      s_arvalid = 1'b0;
      checks++; if (s_rvalid !== 1'b1 || s_rdata !== 8'hA4 || s_arready !== 1'b1) begin errors++;
         $display("FAIL b2b_second: got rv=%b d=%h arr=%b expected 1 a4 1", s_rvalid, s_rdata, s_arready); end
      tick();
      model_read(4'd3);
      model_read(4'd7);
      checks++; if (s_rvalid !== 1'b0 || disp_hex !== model_disp) begin errors++;
         $display("FAIL b2b_end: got rv=%b disp=%h expected 0 %h", s_rvalid, disp_hex, model_disp); end
   endtask

   task automatic test_reset_mid();
      logic bv1, bv2, rv; logic [1:0] r; logic [DW-1:0] d; logic [7:0] dh; bit ok;
      s_bready = 1'b1;
      s_awvalid = 1'b1; s_awaddr = 4'd5;
      tick();
      s_awvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1 || disp_hex !== model_disp) begin errors++;
         $display("FAIL mid_reset_async: got bv=%b awr=%b wr=%b disp=%h expected 0 1 1 %h",
                  s_bvalid, s_awready, s_wready, disp_hex, model_disp); end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      s_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (s_bvalid !== 1'b0) begin errors++;
            $display("FAIL mid_reset_nobresp[%0d]: got %b expected 0", i, s_bvalid); end
      end
      for (int i = 0; i < DP; i++) begin
         axi_read(AW'(i), rv, d, r, dh, ok);
         model_read(AW'(i));
         checks++; if (!ok || d !== 8'h00) begin errors++;
            $display("FAIL mid_reset_clear[%0d]: got %h expected 00", i, d); end
      end
      axi_write(4'd5, 8'h3C, 0, 2, bv1, r, bv2, ok);
      model_mem[5] = 8'h3C;
      checks++; if (!ok || bv1 !== 1'b1 || r !== 2'b00 || bv2 !== 1'b0) begin errors++;
         $display("FAIL mid_reset_rewrite: got ok=%0d bv=%b%b br=%b expected 1 10 00", ok, bv1, bv2, r); end
      axi_read(4'd5, rv, d, r, dh, ok);
      model_read(4'd5);
      checks++; if (d !== 8'h3C || dh !== model_disp) begin errors++;
         $display("FAIL mid_reset_readback: got %h/%h expected 3c/%h", d, dh, model_disp); end
   endtask

   task automatic test_random();
      logic bv1, bv2, rv; logic [1:0] r; logic [DW-1:0] d; logic [7:0] dh; bit ok;
      logic [AW-1:0] a; logic [DW-1:0] wd; logic [DW-1:0] ed; logic [1:0] er;
      for (int n = 0; n < 60; n++) begin
         a = AW'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            wd = DW'($urandom);
            er = exp_resp(a);
            axi_write(a, wd, $urandom_range(0, 2), $urandom_range(0, 2), bv1, r, bv2, ok);
            if (int'(a) < DP) model_mem[a] = wd;
            checks++; if (!ok || bv1 !== 1'b1 || r !== er || bv2 !== 1'b0) begin errors++;
               $display("FAIL rand_write[%0d] a=%0d: got ok=%0d bv=%b%b br=%b expected 1 10 %b", n, a, ok, bv1, bv2, r, er); end
         end else begin
            ed = exp_rdata(a);
            er = exp_resp(a);
            axi_read(a, rv, d, r, dh, ok);
            model_read(a);
            checks++; if (!ok || rv !== 1'b1 || d !== ed || r !== er || dh !== model_disp) begin errors++;
               $display("FAIL rand_read[%0d] a=%0d: got %h/%b/%h expected %h/%b/%h", n, a, d, r, dh, ed, er, model_disp); end
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      test_reset();
      test_write_same_cycle();
      test_w_before_aw();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- Parametrised AXI-Lite-style slave register file; next generation of the 4-bit single-channel AXI display slave.
- Adds independent AW/W acceptance, a B response channel, read/write response codes, and configurable data width and depth.
- Adds SLVERR on out-of-range addresses and an optional seven-segment display of the last read value.
- Sits between a board-level master (switch/button sequencer or soft CPU) and display/peripheral logic.

Parameters:
- DATA_W, 8: register and data-bus width; minimum 4.
- ADDR_W, 4: address width.
- DEPTH, 16: number of implemented registers; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_awvalid  in  1  write-address valid.
- s_awaddr  in  ADDR_W  write address.
- s_awready  out  1  write-address ready.
- s_wvalid  in  1  write-data valid.
- s_wdata  in  DATA_W  write data.
- s_wready  out  1  write-data ready.
- s_bvalid  out  1  write-response valid.
- s_bresp  out  2  write response code.
- s_bready  in  1  write-response ready.
- s_arvalid  in  1  read-address valid.
- s_araddr  in  ADDR_W  read address.
- s_arready  out  1  read-address ready.
- s_rvalid  out  1  read-data valid.
- s_rdata  out  DATA_W  read data.
- s_rresp  out  2  read response code.
- s_rready  in  1  read-data ready.
- disp_hex  out  8  seven-segment pattern, active-high; bit0=a … bit6=g, bit7=dp.

Behaviour:
- Reset (async assert, sync release):
  - All registers 0.
  - bvalid, rvalid, bresp, rresp, rdata all 0.
  - awready and wready 1; arready 1.
  - disp_hex per Optional Feature.
- Handshake rules:
  - A handshake completes on a rising edge where valid and ready are both 1.
  - Once asserted, bvalid/rvalid, together with their resp and data, hold stable until the matching ready is seen.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready = 1 in W_IDLE and W_HAVE_W.
  - wready = 1 in W_IDLE and W_HAVE_AW.
  - AW and W may complete on the same edge or in either order; address and data are latched internally.
  - Commit happens on the edge that completes the pair: register written, bvalid=1, state W_RESP.
  - W_RESP → W_IDLE on the bvalid&bready edge.
  - No new AW/W is accepted while in W_RESP.
- Read FSM states: R_IDLE, R_VALID.
  - arready = ~rvalid | rready, giving one read per cycle under continuous rready.
  - On AR handshake: rdata = reg[araddr] and rvalid=1 on that same edge (1-cycle latency).
  - If rready=1 with no new AR, go to R_IDLE and rvalid=0.
- Response codes:
  - Address < DEPTH: resp OKAY (2'b00).
  - Address >= DEPTH: write is dropped, bresp SLVERR (2'b10); read returns rdata 0, rresp SLVERR.
- Same-edge read and write commit to the same address: read returns the pre-write value.
- Data is full-width DATA_W; no strobes and no partial writes.
- An asynchronous reset mid-transaction aborts it: the latched AW/W is discarded and no response is issued.

Optional Feature:
- Macro: AXI_LITE_REGFILE_HEX_DISP_EN.
- Defined:
  - disp_hex is a registered decode of s_rdata[3:0], updated on each OKAY read handshake; SLVERR reads leave it unchanged.
  - Hex 0–F, dp=0; reset value 8'h3F (digit 0).
  - Key patterns: 0=8'h3F, 4=8'h66, 5=8'h6D, A=8'h77, F=8'h71.
- Undefined: disp_hex tied to 8'h00 and the decoder is not instantiated.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY and RESP_SLVERR constants.
  - Write-FSM and read-FSM state enums.
  - 16-entry seven-segment constant table.
- Sub-module hex7seg_dec: combinational nibble → 8-bit segment decoder, instantiated only under the macro.

Test Plan:
1. Reset with rst_n=0 for 2 cycles → all registers 0; read of addr 3 gives rdata 8'h00, rresp 00, disp_hex 8'h3F.
2. AW(addr 3) and W(8'h45) on the same cycle, bready=1 → bvalid for 1 cycle with bresp 00; read addr 3 gives 8'h45 and disp_hex 8'h6D.
3. W(8'hA4) three cycles before AW(addr 7), bready held 0 for 4 cycles:
   - bvalid asserts on the AW edge and stays high;
   - awready and wready stay 0 until bready;
   - read addr 7 gives 8'hA4 and disp_hex 8'h66.
4. With DEPTH=12: write addr 13 → bresp 10 and no register changes; read addr 13 gives rdata 0 and rresp 10; disp_hex unchanged.
5. Back-to-back reads of addr 3 then 7 with rready=1 → arready stays 1; rdata 8'h45 then 8'hA4 on consecutive cycles.
6. Reset asserted between AW and W handshakes → no bvalid; all registers return to 0; next full write completes normally.
